seg7_scan: RTL

Time-multiplexed driver for the four-digit common-anode seven-segment display. It sits directly downstream of the binary-to-BCD converter and captures its thousands/hundreds/tens/ones digits on a load strobe. It then scans them onto shared active-low anode and segment lines, with optional leading-zero blanking and whole-display blink.

---
 rtl/seg7_scan.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/seg7_scan.sv
// Four-digit common-anode seven-segment scanner: captures BCD digits on load, then
// time-multiplexes them onto active-low anode/segment lines with leading-zero blanking and blink.
module seg7_scan #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] tho,
    input  logic [3:0] hun,
    input  logic [3:0] ten,
    input  logic [3:0] one,
    input  logic       load,
    input  logic       blank_lz,
    input  logic       blink,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [RW-1:0] R_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BLINK_DIV - 1);

    logic [3:0]    r_tho, r_hun, r_ten, r_one;
    logic [RW-1:0] r_ref_cnt;
    logic [1:0]    r_idx;
    logic [BW-1:0] r_blink_cnt;
    logic          r_phase;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;

    logic [3:0]    w_digit;
    logic          w_lz_supp;
    logic          w_suppress;
    logic [6:0]    w_seg_dec;
    logic [3:0]    w_an_next;
    logic [6:0]    w_seg_next;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tho <= 4'd0;
            r_hun <= 4'd0;
            r_ten <= 4'd0;
            r_one <= 4'd0;
        end else if (load) begin
            r_tho <= tho;
            r_hun <= hun;
            r_ten <= ten;
            r_one <= one;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ref_cnt <= '0;
            r_idx     <= 2'd0;
        end else if (r_ref_cnt == R_LAST) begin
            r_ref_cnt <= '0;
            r_idx     <= r_idx + 2'd1;
        end else begin
            r_ref_cnt <= r_ref_cnt + 1'b1;
        end
    end

    // Blink is held in its visible phase while disabled, so enabling it always starts lit.
    always_ff @(posedge clk) begin
        if (reset || !blink) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (r_blink_cnt == B_LAST) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_digit   = r_one;
        w_lz_supp = 1'b0;
        case (r_idx)
            2'd0: begin
                w_digit   = r_one;
                w_lz_supp = 1'b0;
            end
            2'd1: begin
                w_digit   = r_ten;
                w_lz_supp = (r_tho == 4'd0) && (r_hun == 4'd0) && (r_ten == 4'd0);
            end
            2'd2: begin
                w_digit   = r_hun;
                w_lz_supp = (r_tho == 4'd0) && (r_hun == 4'd0);
            end
            default: begin
                w_digit   = r_tho;
                w_lz_supp = (r_tho == 4'd0);
            end
        endcase
    end

    always_comb begin
        w_seg_dec = 7'h3F;
        case (w_digit)
            4'd0:    w_seg_dec = 7'h40;
            4'd1:    w_seg_dec = 7'h79;
            4'd2:    w_seg_dec = 7'h24;
            4'd3:    w_seg_dec = 7'h30;
            4'd4:    w_seg_dec = 7'h19;
            4'd5:    w_seg_dec = 7'h12;
            4'd6:    w_seg_dec = 7'h02;
            4'd7:    w_seg_dec = 7'h78;
            4'd8:    w_seg_dec = 7'h00;
            4'd9:    w_seg_dec = 7'h10;
            default: w_seg_dec = 7'h3F;
        endcase
    end

    always_comb begin
        w_suppress = (blank_lz && w_lz_supp) || (blink && r_phase);
        w_an_next  = ~(4'b0001 << r_idx);
        w_seg_next = w_seg_dec;
        if (w_suppress) begin
            w_an_next  = 4'hF;
            w_seg_next = 7'h7F;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_an  <= 4'hF;
            r_seg <= 7'h7F;
        end else begin
            r_an  <= w_an_next;
            r_seg <= w_seg_next;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = 1'b1;

endmodule
